// File: rtl/debug_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_uart_pkg
//  Brief    : Shared constants, FSM state encodings and the baud divisor
//             helper for the debug UART receiver (and the future transmitter).
//  Revision : 1.0 - initial release
// ============================================================================
package debug_uart_pkg;

  localparam int DEFAULT_CLK_FREQ   = 50_000_000;
  localparam int DEFAULT_BAUD       = 19_200;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  // Receiver FSM state encodings
  localparam int         ST_W      = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_WAITHI = 3'd4;

  // Clocks per oversample tick, truncated; never below one clock.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int div_v;
    div_v = clk_freq / (baud * oversample);
    if (div_v < 1) begin
      div_v = 1;
    end
    return div_v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Brief    : Free-running divider producing a one-clock tick every DIV clocks.
//             It is never restarted by line activity.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap to zero on the tick clock
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : debug_uart_rx
//  Brief    : 8N1 LSB-first serial receiver with 16x oversampling, 2-FF
//             synchroniser, 1-deep valid/ready holding register, frame error
//             pulse and sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 tick;
  logic [1:0]           sync_q;
  logic                 rxs;

  logic [ST_W-1:0]      state_q,  state_d;
  logic [TW-1:0]        tcnt_q,   tcnt_d;
  logic [BW-1:0]        bcnt_q,   bcnt_d;
  logic [DATA_BITS-1:0] shreg_q,  shreg_d;
  logic [DATA_BITS-1:0] shift_next;
  logic                 stop_ok;
  logic                 stop_bad;

  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ferr_q,   ferr_d;
  logic                 ovr_q,    ovr_d;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rxs = sync_q[1];

  // New bits enter at the MSB so the first (LSB) bit ends up at bit 0
  generate
    if (DATA_BITS == 1) begin : g_shift_single
      assign shift_next = rxs;
    end else begin : g_shift_multi
      assign shift_next = {rxs, shreg_q[DATA_BITS-1:1]};
    end
  endgenerate

  // Frame FSM: every action happens on an oversample tick
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d = ST_START;
            tcnt_d  = '0;
          end
        end
        ST_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit
          if (tcnt_q == T_HALF) begin
            if (rxs) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            shreg_d = shift_next;
            if (bcnt_q == B_LAST) begin
              state_d = ST_STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (tcnt_q == T_FULL) begin
            if (rxs) begin
              stop_ok = 1'b1;
              state_d = ST_IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = ST_WAITHI;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_WAITHI: begin
          // A held-low break must end before a new start bit is looked for
          if (rxs) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Holding register, frame error pulse and sticky overrun
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = stop_bad;
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (err_clr) begin
      ovr_d = 1'b0;
    end
    if (stop_ok) begin
      if (!valid_q || data_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        // Old byte is kept; a new overrun wins over a same-cycle clear
        ovr_d = 1'b1;
      end
    end
  end

  // State registers; reset abandons any frame in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_uart_rx
//  Brief    : Self-checking bench for debug_uart_rx: expected bytes are queued
//             as frames are issued and popped by a monitor on each accept.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_uart_rx;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       rx         = 1'b1;
  logic       data_ready = 1'b0;
  logic       err_clr    = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int errors   = 0;
  int fe_cnt   = 0;
  int accepted = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         exp_fe      = 0;
  logic       exp_overrun = 1'b0;
  logic       stalled     = 1'b0;
  logic       hold_busy   = 1'b0;
  logic [7:0] mon_exp;
  logic       rand_done;

  always #5 clk = ~clk;

  debug_uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A frame is delivered unless its stop bit is low; it is lost (overrun)
  // if an earlier byte is still held for a stalled consumer.
  task automatic model_send(input logic [7:0] b, input logic stop_good);
    if (!stop_good) begin
      exp_fe++;
    end else if (hold_busy) begin
      exp_overrun = 1'b1;
    end else begin
      exp_q.push_back(b);
      hold_busy = stalled;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int low_after);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop;
    wait_clks(BIT_CLKS);
    if (low_after > 0) begin
      rx = 1'b0;
      wait_clks(BIT_CLKS * low_after);
    end
    rx = 1'b1;
  endtask

  // Monitor: compare every accepted byte against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) fe_cnt++;
      if (data_valid && data_ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, expected no byte", data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_byte", {24'd0, data}, {24'd0, mon_exp});
        end
      end
    end
  end

  initial begin
    logic [7:0] rb;
    int         acc0;
    // Reset state
    reset = 1'b0;
    wait_clks(9);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    wait_clks(BIT_CLKS);

    // 1: plain frame, consumer always ready
    data_ready = 1'b1;
    model_send(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, 0);
    wait_clks(BIT_CLKS);
    check("t1_fe", fe_cnt, exp_fe);
    check("t1_ovr", {31'd0, overrun}, {31'd0, exp_overrun});
    check("t1_drained", exp_q.size(), 0);

    // 2: consumer stalls, byte must be held stable
    data_ready = 1'b0;
    stalled    = 1'b1;
    model_send(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, 0);
    check("t2_valid_a", {31'd0, data_valid}, 32'd1);
    check("t2_data_a", {24'd0, data}, 32'h3C);
    wait_clks(500);
    check("t2_valid_b", {31'd0, data_valid}, 32'd1);
    check("t2_data_b", {24'd0, data}, 32'h3C);
    data_ready = 1'b1;
    stalled    = 1'b0;
    hold_busy  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t2_valid_drop", {31'd0, data_valid}, 32'd0);
    check("t2_drained", exp_q.size(), 0);
    wait_clks(BIT_CLKS);

    // 3: back-to-back frames into a stalled consumer
    data_ready = 1'b0;
    stalled    = 1'b1;
    model_send(8'h11, 1'b1);
    model_send(8'h22, 1'b1);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    wait_clks(20);
    check("t3_data", {24'd0, data}, 32'h11);
    check("t3_valid", {31'd0, data_valid}, 32'd1);
    check("t3_ovr_set", {31'd0, overrun}, {31'd0, exp_overrun});
    err_clr = 1'b1;
    wait_clks(1);
    err_clr     = 1'b0;
    exp_overrun = 1'b0;
    check("t3_ovr_clr", {31'd0, overrun}, {31'd0, exp_overrun});
    data_ready = 1'b1;
    stalled    = 1'b0;
    hold_busy  = 1'b0;
    wait_clks(5);
    check("t3_drained", exp_q.size(), 0);
    wait_clks(BIT_CLKS);

    // 4: bad stop bit followed by a long break, then a good frame
    model_send(8'h55, 1'b0);
    send_frame(8'h55, 1'b0, 3);
    wait_clks(2 * BIT_CLKS);
    check("t4_fe", fe_cnt, exp_fe);
    check("t4_valid", {31'd0, data_valid}, 32'd0);
    model_send(8'h0F, 1'b1);
    send_frame(8'h0F, 1'b1, 0);
    wait_clks(BIT_CLKS);
    check("t4_drained", exp_q.size(), 0);

    // 5: short low glitch must be ignored, then a frame still works
    acc0 = accepted;
    rx   = 1'b0;
    wait_clks(40);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("t5_fe", fe_cnt, exp_fe);
    check("t5_none", accepted - acc0, 0);
    rb = 8'($urandom);
    model_send(rb, 1'b1);
    send_frame(rb, 1'b1, 0);
    wait_clks(BIT_CLKS);
    check("t5_drained", exp_q.size(), 0);

    // 6: reset in the middle of a frame
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        wait_clks(4 * BIT_CLKS + 30);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", {31'd0, data_valid}, 32'd0);
        check("t6_rst_data", {24'd0, data}, 32'd0);
        check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
        wait_clks(9);
        reset = 1'b1;
      end
    join
    wait_clks(BIT_CLKS);
    acc0 = accepted;
    model_send(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, 0);
    wait_clks(2 * BIT_CLKS);
    check("t6_one_byte", accepted - acc0, 1);

    // Randomised bytes, gaps and consumer ready pattern
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          rb = 8'($urandom);
          model_send(rb, 1'b1);
          send_frame(rb, 1'b1, 0);
          wait_clks(int'($urandom_range(0, 80)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          data_ready = 1'($urandom_range(0, 1));
          wait_clks(1);
        end
        data_ready = 1'b1;
      end
    join

    // Bounded drain of anything still expected
    for (int w = 0; w < 3000 && exp_q.size() != 0; w++) begin
      wait_clks(1);
    end
    check("end_drained", exp_q.size(), 0);
    check("end_fe", fe_cnt, exp_fe);
    check("end_ovr", {31'd0, overrun}, {31'd0, exp_overrun});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
